// File: rtl/seg7_if.sv
// Bundle of display-side signals between the digit source/pins and seg7_scan.
interface seg7_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;

    modport master (output en, load, digits, dp_in, input an, seg, dp);
    modport slave  (input en, load, digits, dp_in, output an, seg, dp);
endinterface

// File: rtl/seg7_scan.sv
// Multiplexed common-anode 7-segment driver with double-buffered digits and per-slot dead time.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic     clk,
    input  logic     rst,
    seg7_if.slave    bus
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [4*DIGITS-1:0]    hold_dig_q, shown_dig_q;
    logic [DIGITS-1:0]      hold_dp_q, shown_dp_q;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;
    logic                   dp_q, dp_d;

    logic                   in_blank, wrap, cur_dp, lzb_blank;
    logic [3:0]             cur_dig;
    logic [IW-1:0]          idx_nxt;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign in_blank = 32'(cnt_q) < 32'(BLANK_CYC);
    assign wrap     = cnt_q == CW'(SCAN_DIV - 1);
    assign idx_nxt  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        cur_dig = '0;
        cur_dp  = 1'b0;
        an_d    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_dig = shown_dig_q[i*4 +: 4];
                cur_dp  = shown_dp_q[i];
                an_d[i] = in_blank;
            end
        end
    end

`ifdef SEG7_LZB_EN
    // A digit is suppressed when it and all digits to its left are zero; digit 0 always shows.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lzb_blank = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (shown_dig_q[i*4 +: 4] == 4'd0);
            if (idx_q == IW'(i))
                lzb_blank = all_zero;
        end
    end
`else
    assign lzb_blank = 1'b0;
`endif

    assign seg_d = (in_blank || lzb_blank) ? 7'h7F : decode(cur_dig);
    assign dp_d  = in_blank ? 1'b1 : ~cur_dp;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            idx_q       <= '0;
            hold_dig_q  <= '0;
            hold_dp_q   <= '0;
            shown_dig_q <= '0;
            shown_dp_q  <= '0;
            an_q        <= '1;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            if (bus.load) begin
                hold_dig_q <= bus.digits;
                hold_dp_q  <= bus.dp_in;
            end
            if (!bus.en) begin
                cnt_q       <= '0;
                idx_q       <= '0;
                shown_dig_q <= hold_dig_q;
                shown_dp_q  <= hold_dp_q;
                an_q        <= '1;
                seg_q       <= 7'h7F;
                dp_q        <= 1'b1;
            end else begin
                an_q  <= an_d;
                seg_q <= seg_d;
                dp_q  <= dp_d;
                // Shown buffer only changes at a slot boundary so a slot never mixes frames.
                if (wrap) begin
                    cnt_q       <= '0;
                    idx_q       <= idx_nxt;
                    shown_dig_q <= hold_dig_q;
                    shown_dp_q  <= hold_dp_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;
endmodule
